// File: rtl/ram8_arbiter.sv
// ram8_arbiter: shares a single RAM8 between two single-word requesters (A and B).
// Each granted transaction runs IDLE -> ACCESS -> DONE -> IDLE. Simultaneous
// requests are resolved round-robin against the most recent grantee.
module ram8_arbiter #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_wdata,
  output logic             a_ack,
  output logic [WIDTH-1:0] a_rdata,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] b_wdata,
  output logic             b_ack,
  output logic [WIDTH-1:0] b_rdata,
  output logic [WIDTH-1:0] ram_in,
  output logic             ram_load,
  output logic [AW-1:0]    ram_address,
  input  logic [WIDTH-1:0] ram_out,
  output logic             busy,
  output logic             owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             we_r;
  logic [AW-1:0]    addr_r;
  logic [WIDTH-1:0] wdata_r;
  logic             any_req;
  logic             grant_b;
  logic [WIDTH-1:0] capture_word;

  // B wins when it is the only requester, or on a tie when A was served last.
  assign any_req      = a_req | b_req;
  assign grant_b      = b_req & (~a_req | ~owner);
  // Writes echo their own data back; reads take the RAM word seen during ACCESS.
  assign capture_word = we_r ? wdata_r : ram_out;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: a request in IDLE starts a fixed three-cycle transaction.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant: record the winner and freeze its transaction fields for the access.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner   <= 1'b1;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else if (state == IDLE && any_req) begin
      owner   <= grant_b;
      we_r    <= grant_b ? b_we    : a_we;
      addr_r  <= grant_b ? b_addr  : a_addr;
      wdata_r <= grant_b ? b_wdata : a_wdata;
    end
  end

  // Result capture at the close of ACCESS; only the owner's register moves.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else if (state == ACCESS) begin
      if (owner) begin
        b_rdata <= capture_word;
      end else begin
        a_rdata <= capture_word;
      end
    end
  end

  // Outputs depend only on registered state; reset suppresses an in-flight write.
  always_comb begin
    a_ack       = (state == DONE) & ~owner;
    b_ack       = (state == DONE) & owner;
    busy        = (state != IDLE);
    ram_load    = (state == ACCESS) & we_r & ~reset;
    ram_address = addr_r;
    ram_in      = wdata_r;
  end

endmodule

// File: tb/tb_ram8_arbiter.sv
// Testbench for ram8_arbiter: directed table, multi-cycle sequences and random
// traffic, with a transaction-timestamp reference model and a RAM8 behavioural model.
module tb_ram8_arbiter;

  logic        clk;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [2:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ack, b_ack;
  logic [15:0] a_rdata, b_rdata;
  logic [15:0] ram_in, ram_out;
  logic        ram_load;
  logic [2:0]  ram_address;
  logic        busy, owner;

  int checks;
  int failures;

  ram8_arbiter #(.WIDTH(16), .AW(3)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address),
    .ram_out(ram_out), .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM8: synchronous write on load, combinational read.
  logic [15:0] ram_mem [8];
  initial for (int i = 0; i < 8; i++) ram_mem[i] = 16'h0000;
  always @(posedge clk) if (ram_load) ram_mem[ram_address] <= ram_in;
  assign ram_out = ram_mem[ram_address];

  // Reference model: a transaction is granted at edge last_grant, commits at
  // last_grant+1, acks during the following cycle, and the port is free again
  // three edges after the grant.
  int          edge_n;
  int          last_grant;
  bit          m_owner;
  bit          m_we;
  logic [2:0]  m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_ard, m_brd;
  logic [15:0] mm [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic [15:0] word;
    bit pick_b;
    edge_n++;
    if (reset) begin
      last_grant = -100;
      m_owner = 1'b1; m_we = 1'b0; m_addr = 3'd0; m_wdata = 16'h0;
      m_ard = 16'h0; m_brd = 16'h0;
    end else if (edge_n - last_grant == 1) begin
      word = m_we ? m_wdata : mm[m_addr];
      if (m_we) mm[m_addr] = m_wdata;
      if (m_owner) m_brd = word; else m_ard = word;
    end else if (edge_n - last_grant >= 3 && (a_req || b_req)) begin
      if (a_req && b_req) pick_b = !m_owner;
      else pick_b = b_req;
      last_grant = edge_n;
      m_owner = pick_b;
      m_we    = pick_b ? b_we    : a_we;
      m_addr  = pick_b ? b_addr  : a_addr;
      m_wdata = pick_b ? b_wdata : a_wdata;
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic settle_check();
    int age;
    #1;
    age = edge_n - last_grant;
    chk("m_busy",     busy,     (age == 0 || age == 1));
    chk("m_a_ack",    a_ack,    (age == 1 && !m_owner));
    chk("m_b_ack",    b_ack,    (age == 1 && m_owner));
    chk("m_ram_load", ram_load, (age == 0 && m_we && !reset));
    chk("m_owner",    owner,    m_owner);
    chk("m_a_rdata",  a_rdata,  m_ard);
    chk("m_b_rdata",  b_rdata,  m_brd);
    chk("m_ram_addr", ram_address, m_addr);
    chk("m_ram_in",   ram_in,   m_wdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      settle_check();
      edge_step();
    end
  endtask

  task automatic txn(input bit port, input bit we, input logic [2:0] addr,
                     input logic [15:0] wd, output logic [15:0] rd, output int lat);
    if (port) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
    else      begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      settle_check();
      edge_step();
      if (port ? b_ack : a_ack) begin
        lat = k;
        break;
      end
    end
    rd = port ? b_rdata : a_rdata;
    if (port) b_req = 0; else a_req = 0;
    if (lat < 0) chk("txn_timeout", 32'd1, 32'd0);
  endtask

  typedef struct {
    bit          rst;
    bit          ar, awe;
    logic [2:0]  aa;
    logic [15:0] awd;
    bit          br, bwe;
    logic [2:0]  ba;
    logic [15:0] bwd;
    bit          e_busy, e_owner, e_aack, e_back;
    logic [15:0] e_ard, e_brd;
    bit          e_load;
  } row_t;

  row_t tbl [13];

  initial begin
    logic [15:0] rd;
    int lat;
    int ack_cnt;
    int ack_who [6];
    int ack_at  [6];
    bit  both_seen;

    checks = 0; failures = 0;
    edge_n = 0; last_grant = -100;
    m_owner = 1; m_we = 0; m_addr = 0; m_wdata = 0; m_ard = 0; m_brd = 0;
    for (int i = 0; i < 8; i++) mm[i] = 16'h0;
    reset = 1;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    edge_step();

    //         rst ar awe aa  awd       br bwe ba  bwd      busy own aack back ard       brd       load
    tbl[0]  = '{1, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 0};
    tbl[1]  = '{0, 1, 1, 3, 16'hAAAA, 1, 0, 3, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 0};
    tbl[2]  = '{0, 1, 1, 3, 16'hAAAA, 1, 0, 3, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h0000, 1};
    tbl[3]  = '{0, 0, 0, 0, 16'h0000, 1, 0, 3, 16'h0000, 1, 0, 1, 0, 16'hAAAA, 16'h0000, 0};
    tbl[4]  = '{0, 0, 0, 0, 16'h0000, 1, 0, 3, 16'h0000, 0, 0, 0, 0, 16'hAAAA, 16'h0000, 0};
    tbl[5]  = '{0, 0, 0, 0, 16'h0000, 1, 0, 3, 16'h0000, 1, 1, 0, 0, 16'hAAAA, 16'h0000, 0};
    tbl[6]  = '{0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 1, 0, 1, 16'hAAAA, 16'hAAAA, 0};
    tbl[7]  = '{0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'hAAAA, 16'hAAAA, 0};
    tbl[8]  = '{1, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'hAAAA, 16'hAAAA, 0};
    tbl[9]  = '{0, 1, 0, 3, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 0};
    tbl[10] = '{0, 1, 0, 3, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h0000, 0};
    tbl[11] = '{1, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 1, 0, 16'hAAAA, 16'h0000, 0};
    tbl[12] = '{0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 0};

    for (int r = 0; r < 13; r++) begin
      reset = tbl[r].rst;
      a_req = tbl[r].ar; a_we = tbl[r].awe; a_addr = tbl[r].aa; a_wdata = tbl[r].awd;
      b_req = tbl[r].br; b_we = tbl[r].bwe; b_addr = tbl[r].ba; b_wdata = tbl[r].bwd;
      settle_check();
      chk($sformatf("tbl%0d_busy", r),  busy,     tbl[r].e_busy);
      chk($sformatf("tbl%0d_owner", r), owner,    tbl[r].e_owner);
      chk($sformatf("tbl%0d_aack", r),  a_ack,    tbl[r].e_aack);
      chk($sformatf("tbl%0d_back", r),  b_ack,    tbl[r].e_back);
      chk($sformatf("tbl%0d_ard", r),   a_rdata,  tbl[r].e_ard);
      chk($sformatf("tbl%0d_brd", r),   b_rdata,  tbl[r].e_brd);
      chk($sformatf("tbl%0d_load", r),  ram_load, tbl[r].e_load);
      edge_step();
    end

    // A writes 0x1000..0x7000 to addresses 1..7, then reads 0..7 back.
    for (int i = 1; i < 8; i++) begin
      txn(0, 1, i[2:0], 16'(i * 16'h1000), rd, lat);
      chk("a_wr_lat", lat, 2);
      chk("a_wr_echo", rd, 16'(i * 16'h1000));
      idle(1);
    end
    for (int i = 0; i < 8; i++) begin
      txn(0, 0, i[2:0], 16'h0, rd, lat);
      chk("a_rd_lat", lat, 2);
      chk($sformatf("a_rd_%0d", i), rd, 16'(i * 16'h1000));
      idle(1);
    end

    // Persistent contention after reset: grants alternate starting with A.
    reset = 1;
    idle(2);
    reset = 0;
    a_req = 1; a_we = 0; a_addr = 3'd1;
    b_req = 1; b_we = 0; b_addr = 3'd2;
    ack_cnt = 0; both_seen = 0;
    for (int k = 1; k <= 40 && ack_cnt < 6; k++) begin
      settle_check();
      edge_step();
      if (a_ack && b_ack) both_seen = 1;
      if (a_ack || b_ack) begin
        ack_who[ack_cnt] = b_ack ? 1 : 0;
        ack_at[ack_cnt]  = k;
        ack_cnt++;
      end
    end
    a_req = 0; b_req = 0;
    chk("cont_count", ack_cnt, 6);
    chk("cont_both", both_seen, 0);
    if (ack_cnt == 6) begin
      chk("cont_first_at", ack_at[0], 2);
      for (int i = 0; i < 6; i++) chk($sformatf("cont_who%0d", i), ack_who[i], i % 2);
      for (int i = 1; i < 6; i++) chk($sformatf("cont_gap%0d", i), ack_at[i] - ack_at[i-1], 3);
    end
    idle(1);

    // Reset during ACCESS of a write: no commit, no ack.
    a_req = 1; a_we = 1; a_addr = 3'd5; a_wdata = 16'h5555;
    settle_check();
    edge_step();
    reset = 1; a_req = 0;
    settle_check();
    chk("racc_load", ram_load, 0);
    chk("racc_busy", busy, 1);
    edge_step();
    reset = 0;
    chk("racc_busy_after", busy, 0);
    for (int i = 0; i < 3; i++) begin
      settle_check();
      chk("racc_no_ack", a_ack, 0);
      edge_step();
    end
    txn(0, 0, 3'd5, 16'h0, rd, lat);
    chk("racc_old_word", rd, 16'h5000);
    idle(1);

    // B alone reads every address; A's side stays untouched.
    for (int i = 0; i < 8; i++) begin
      txn(1, 0, i[2:0], 16'h0, rd, lat);
      chk($sformatf("b_rd_%0d", i), rd, 16'(i * 16'h1000));
      chk("b_only_owner", owner, 1);
      chk("b_only_ardata", a_rdata, 16'h5000);
      chk("b_only_aack", a_ack, 0);
      idle(1);
    end

    // Random traffic with occasional resets, checked cycle by cycle.
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 60) == 0);
      if (a_req && a_ack) begin
        a_req = $urandom_range(0, 1);
        a_we = $urandom_range(0, 1); a_addr = 3'($urandom_range(0, 7)); a_wdata = 16'($urandom);
      end else if (!a_req && $urandom_range(0, 2) == 0) begin
        a_req = 1;
        a_we = $urandom_range(0, 1); a_addr = 3'($urandom_range(0, 7)); a_wdata = 16'($urandom);
      end
      if (b_req && b_ack) begin
        b_req = $urandom_range(0, 1);
        b_we = $urandom_range(0, 1); b_addr = 3'($urandom_range(0, 7)); b_wdata = 16'($urandom);
      end else if (!b_req && $urandom_range(0, 2) == 0) begin
        b_req = 1;
        b_we = $urandom_range(0, 1); b_addr = 3'($urandom_range(0, 7)); b_wdata = 16'($urandom);
      end
      settle_check();
      edge_step();
    end
    reset = 0; a_req = 0; b_req = 0;
    idle(4);
    for (int i = 0; i < 8; i++) chk($sformatf("ram_word%0d", i), ram_mem[i], mm[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
